// File: rtl/word_serializer_if.sv
// Word-in / chunk-out channel bundle for word_serializer.
// master = serializer side, slave = encoder/sink side.
interface word_serializer_if #(
  parameter int WORD_W     = 24,
  parameter int CHUNK_W    = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [WORD_W-1:0]  in_data;
  logic               write;
  logic               ready;
  logic [CHUNK_W-1:0] out_chunk;
  logic               out_valid;
  logic               out_ready;
  logic               out_first;
  logic               out_last;
  logic [CW-1:0]      fifo_count;
  logic               overflow;

  modport master (
    input  in_data, write, out_ready,
    output ready, out_chunk, out_valid,
    output out_first, out_last,
    output fifo_count, overflow
  );

  modport slave (
    output in_data, write, out_ready,
    input  ready, out_chunk, out_valid,
    input  out_first, out_last,
    input  fifo_count, overflow
  );
endinterface

// File: rtl/word_serializer.sv
// Queues words in a small FIFO and emits them MSB-first as chunks.
// SER_PARITY_EN appends an even-parity chunk after each word.
module word_serializer #(
  parameter int WORD_W     = 24,
  parameter int CHUNK_W    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  word_serializer_if.master bus
);
  localparam int NCHUNK = WORD_W / CHUNK_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int IW     = $clog2(NCHUNK);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t            state;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [WORD_W-1:0] shift_reg;
  logic [IW-1:0]     idx;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow_q;
`ifdef SER_PARITY_EN
  logic              par;
`endif

  logic full;
  logic push;
  logic pop;
  logic word_end;
  logic done;

  assign full     = (count == FULL);
  assign push     = bus.write & ~full;
  assign word_end = (state == SHIFT) & (idx == LAST) & bus.out_ready;

`ifdef SER_PARITY_EN
  assign done = (state == PARITY) & bus.out_ready;
`else
  assign done = word_end;
`endif

  // Popping on the final accept keeps back-to-back words bubble-free.
  assign pop = ((state == IDLE) | done) & (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      idx        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
`ifdef SER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.write & full) overflow_q <= 1'b1;
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        idx       <= '0;
        state     <= SHIFT;
`ifdef SER_PARITY_EN
        par       <= ^mem[rd_ptr];
`endif
      end else if ((state == SHIFT) & bus.out_ready) begin
        shift_reg <= {shift_reg[WORD_W-CHUNK_W-1:0],
                      {CHUNK_W{1'b0}}};
        idx       <= idx + IW'(1);
`ifdef SER_PARITY_EN
        if (word_end) state <= PARITY;
`else
        if (word_end) state <= IDLE;
`endif
`ifdef SER_PARITY_EN
      end else if (done) begin
        state <= IDLE;
`endif
      end
    end
  end

  assign bus.ready      = ~full;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;
  assign bus.out_valid  = (state != IDLE);
  assign bus.out_first  = (state == SHIFT) & (idx == '0);

`ifdef SER_PARITY_EN
  assign bus.out_chunk = (state == PARITY) ? CHUNK_W'(par)
                       : shift_reg[WORD_W-1 -: CHUNK_W];
  assign bus.out_last  = (state == PARITY);
`else
  assign bus.out_chunk = shift_reg[WORD_W-1 -: CHUNK_W];
  assign bus.out_last  = (state == SHIFT) & (idx == LAST);
`endif
endmodule

// File: doc/word_serializer.md
# word_serializer

Parametrised successor to the fixed 24-bit/4-bit buffer stage on the encoding-to-decoding link. It accepts whole words from the encoder through a small input FIFO and emits them as MSB-first chunks over a valid/ready channel toward the link/unbuffer side. Compared with the fixed stage, it adds:
- configurable word and chunk widths;
- queuing of several words;
- output backpressure;
- frame markers;
- optional per-word parity.

## Interface
Parameters:
- WORD_W, 24, word width in bits; must be an exact multiple of CHUNK_W
- CHUNK_W, 4, chunk width in bits; NCHUNK = WORD_W/CHUNK_W, must be ≥ 2
- FIFO_DEPTH, 4, input FIFO depth in words; power of two, ≥ 2

Ports:
- clk  in  1  rising-edge clock, the single clock domain
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_data  in  WORD_W  word to queue
- write  in  1  queue in_data on this edge when ready=1
- ready  out  1  FIFO not full
- out_chunk  out  CHUNK_W  current chunk
- out_valid  out  1  out_chunk is valid
- out_ready  in  1  sink accepts the chunk on this edge
- out_first  out  1  current chunk is the first of a word
- out_last  out  1  current chunk is the last of a word (or its parity chunk)
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words held in the FIFO (excludes the word being shifted)
- overflow  out  1  sticky: a write was attempted while ready=0

## Operation
- FIFO behaviour:
  - A write is accepted when write=1 and ready=1.
  - A write attempted when ready=0 is dropped and sets overflow; overflow clears only on reset.
  - ready depends only on the fullness of the current cycle. A write to a full FIFO is dropped even if a pop happens on the same edge.
- State machine has three states: IDLE, SHIFT, PARITY (PARITY exists only with the macro defined).
- IDLE: when fifo_count≠0, pop the head word into the shift register and go to SHIFT. out_valid=0 while in IDLE.
- SHIFT:
  - out_chunk = shift_reg[WORD_W-1 -: CHUNK_W], so chunk 0 is the MSBs.
  - A chunk index counter runs from 0 to NCHUNK-1.
  - On each edge with out_valid&out_ready, shift left by CHUNK_W and increment the index.
  - out_valid and out_chunk hold stable while out_ready=0.
- End of word, on the edge that accepts chunk NCHUNK-1:
  - with parity: go to PARITY;
  - else if the FIFO is non-empty: pop the next word and stay in SHIFT, with no bubble;
  - else: go to IDLE.
- PARITY: on acceptance, follow the same pop/IDLE rule as the end of a word.
- Markers:
  - out_first=1 exactly when the index is 0 in SHIFT.
  - out_last=1 on index NCHUNK-1 without parity, or in PARITY with parity.
- Simultaneous events: a push and a pop on the same edge leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-word: the partial word is discarded, the FIFO is emptied, and no chunk is emitted.

## Timing
- Reset values:
  - ready=1, out_valid=0, out_first=0, out_last=0;
  - out_chunk=0, fifo_count=0, overflow=0;
  - state IDLE, pointers 0.
- All outputs are registered, or decoded from registered state only. There is no combinational path from write or out_ready to any output.
- Latency for a word written at edge E0 into an empty, idle block:
  - fifo_count=1 after E0;
  - the word is popped at E1;
  - the first chunk is valid after E1.
- Throughput with out_ready held at 1: one chunk per cycle. A word occupies NCHUNK cycles, or NCHUNK+1 with parity.

## Configuration
- SER_PARITY_EN defined:
  - after each word's last data chunk, one extra chunk is emitted;
  - bit 0 = XOR of all WORD_W bits (even parity), other bits 0;
  - out_last moves to that chunk.
- SER_PARITY_EN undefined:
  - the PARITY state and its logic are absent;
  - a word is exactly NCHUNK chunks.

## Test plan
- Reset, then write 24'hB98EA1 with out_ready=1 (no macro) -> out_chunk B,9,8,E,A,1 on 6 consecutive cycles starting 2 edges after the write; out_first on B; out_last on 1; then out_valid=0.
- Write 24'hB98EA1 then 24'h000000 on consecutive edges -> 12 consecutive chunks, with no gap between 1 and the following 0.
- Hold out_ready=0 and write 5 words -> fifo_count reaches 4 after 5 edges (1 word popped into the shift register), ready=0; a 6th write sets overflow=1 and that word never appears on out_chunk.
- Toggle out_ready 1/0 every cycle during a word -> each chunk is held while out_ready=0; the sequence is unchanged with no duplicates.
- With SER_PARITY_EN: 24'hB98EA1 -> 7th chunk 4'h0 with out_last; 24'h000001 -> 7th chunk 4'h1.
- Drive reset low during chunk 3 of a word while 2 words are queued -> immediately out_valid=0, fifo_count=0, overflow=0; after release the block stays idle.
